// File: rtl/udma_hyper_cs_pkg.sv
// Shared types and constants for the HyperBus chip-select burst timer.
package udma_hyper_cs_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StRecover
  } cs_state_e;

  // Fixed command/address cycles spent with CS low before any latency or data.
  localparam int unsigned CMD_OVERHEAD = 3;

  // Width of the saturating statistics counters.
  localparam int unsigned SAT_W = 16;

endpackage

// File: rtl/udma_hyper_chunk_calc.sv
// Combinational burst sizing: CS-low overhead, clamp/saturate of the word budget,
// and min(remaining, budget).
module udma_hyper_chunk_calc
  import udma_hyper_cs_pkg::*;
#(
  parameter int unsigned TRANS_SIZE = 16
) (
  input  logic [31:0]           cs_max_i,
  input  logic [4:0]            lat_i,
  input  logic                  add_i,
  input  logic [TRANS_SIZE-1:0] remaining_i,
  output logic [TRANS_SIZE-1:0] chunk_o,
  output logic                  last_o
);

  localparam logic signed [32:0] SatMax = 33'((64'd1 << TRANS_SIZE) - 64'd1);

  logic [6:0]            overhead;
  logic signed [32:0]    max_s;
  logic [TRANS_SIZE-1:0] max_words;

  always_comb begin
    overhead = 7'(CMD_OVERHEAD) + (add_i ? {1'b0, lat_i, 1'b0} : {2'b00, lat_i});
    max_s    = $signed({1'b0, cs_max_i}) - $signed({26'd0, overhead});
    // Budget of zero or less still moves one word so the transaction makes progress.
    if (max_s <= 33'sd0) begin
      max_words = TRANS_SIZE'(1);
    end else if (max_s > SatMax) begin
      max_words = '1;
    end else begin
      max_words = max_s[TRANS_SIZE-1:0];
    end
    chunk_o = (remaining_i < max_words) ? remaining_i : max_words;
    last_o  = (chunk_o == remaining_i);
  end

endmodule

// File: rtl/udma_hyper_cs_timer.sv
// Splits HyperBus transactions into CS-limited bursts paced by recovery cycles.
// Optional statistics counters are built when UDMA_HYPER_CS_STATS_EN is defined.
module udma_hyper_cs_timer
  import udma_hyper_cs_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           cfg_t_cs_max_i,
  input  logic [31:0]           cfg_t_read_write_recovery_i,
  input  logic [4:0]            cfg_t_latency_access_i,
  input  logic                  cfg_en_latency_additional_i,
  input  logic                  trans_valid_i,
  output logic                  trans_ready_o,
  input  logic [ADDR_W-1:0]     trans_addr_i,
  input  logic [TRANS_SIZE-1:0] trans_size_i,
  input  logic                  trans_rwn_i,
  output logic                  burst_valid_o,
  input  logic                  burst_ready_i,
  output logic [ADDR_W-1:0]     burst_addr_o,
  output logic [TRANS_SIZE-1:0] burst_len_o,
  output logic                  burst_rwn_o,
  output logic                  burst_last_o,
  input  logic                  burst_done_i,
  output logic                  busy_o,
  output logic                  size_err_o,
  output logic [SAT_W-1:0]      stat_bursts_o,
  output logic [SAT_W-1:0]      stat_splits_o
);

  cs_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [TRANS_SIZE-1:0] remaining_q, remaining_d;
  logic                  rwn_q, rwn_d;
  logic [31:0]           cs_max_q, cs_max_d;
  logic [31:0]           rec_q, rec_d;
  logic [31:0]           rec_cnt_q, rec_cnt_d;
  logic [4:0]            lat_q, lat_d;
  logic                  add_q, add_d;
  logic                  size_err_q, size_err_d;
  logic                  first_q, first_d;

  logic [TRANS_SIZE-1:0] chunk;
  logic                  last;
  logic                  burst_hs;

  udma_hyper_chunk_calc #(
    .TRANS_SIZE (TRANS_SIZE)
  ) u_chunk_calc (
    .cs_max_i    (cs_max_q),
    .lat_i       (lat_q),
    .add_i       (add_q),
    .remaining_i (remaining_q),
    .chunk_o     (chunk),
    .last_o      (last)
  );

  assign burst_hs = (state_q == StIssue) && burst_ready_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    rwn_d       = rwn_q;
    cs_max_d    = cs_max_q;
    rec_d       = rec_q;
    rec_cnt_d   = rec_cnt_q;
    lat_d       = lat_q;
    add_d       = add_q;
    size_err_d  = 1'b0;
    first_d     = first_q;
    unique case (state_q)
      StIdle: begin
        if (trans_valid_i) begin
          addr_d      = trans_addr_i;
          remaining_d = trans_size_i;
          rwn_d       = trans_rwn_i;
          cs_max_d    = cfg_t_cs_max_i;
          rec_d       = cfg_t_read_write_recovery_i;
          lat_d       = cfg_t_latency_access_i;
          add_d       = cfg_en_latency_additional_i;
          first_d     = 1'b1;
          if (trans_size_i == '0) begin
            size_err_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (burst_ready_i) begin
          addr_d      = addr_q + ADDR_W'({chunk, 1'b0});
          remaining_d = remaining_q - chunk;
          first_d     = 1'b0;
          state_d     = StWaitDone;
        end
      end
      StWaitDone: begin
        if (burst_done_i) begin
          if (rec_q != '0) begin
            rec_cnt_d = rec_q - 32'd1;
            state_d   = StRecover;
          end else begin
            state_d = (remaining_q != '0) ? StIssue : StIdle;
          end
        end
      end
      StRecover: begin
        if (rec_cnt_q == '0) begin
          state_d = (remaining_q != '0) ? StIssue : StIdle;
        end else begin
          rec_cnt_d = rec_cnt_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      rwn_q       <= 1'b0;
      cs_max_q    <= '0;
      rec_q       <= '0;
      rec_cnt_q   <= '0;
      lat_q       <= '0;
      add_q       <= 1'b0;
      size_err_q  <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      rwn_q       <= rwn_d;
      cs_max_q    <= cs_max_d;
      rec_q       <= rec_d;
      rec_cnt_q   <= rec_cnt_d;
      lat_q       <= lat_d;
      add_q       <= add_d;
      size_err_q  <= size_err_d;
      first_q     <= first_d;
    end
  end

  assign trans_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign burst_valid_o = (state_q == StIssue);
  assign burst_addr_o  = addr_q;
  assign burst_rwn_o   = rwn_q;
  // Gated so idle outputs read zero even though chunk/last follow cleared registers.
  assign burst_len_o   = burst_valid_o ? chunk : '0;
  assign burst_last_o  = burst_valid_o & last;
  assign size_err_o    = size_err_q;

`ifdef UDMA_HYPER_CS_STATS_EN
  logic [SAT_W-1:0] bursts_q, splits_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bursts_q <= '0;
      splits_q <= '0;
    end else begin
      if (burst_hs && (bursts_q != '1)) begin
        bursts_q <= bursts_q + SAT_W'(1);
      end
      if (burst_hs && first_q && !last && (splits_q != '1)) begin
        splits_q <= splits_q + SAT_W'(1);
      end
    end
  end

  assign stat_bursts_o = bursts_q;
  assign stat_splits_o = splits_q;
`else
  logic unused_stats;
  assign unused_stats  = burst_hs ^ first_q;
  assign stat_bursts_o = '0;
  assign stat_splits_o = '0;
`endif

endmodule
